// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side control bundle: decode operands and redirect/busy requests in,
// stall/flush/freeze, operand bypass selects, retire info and counters out.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 32
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  // dec_valid qualifies every dec_* field in the same cycle; there is no
  // ready: a held instruction is signalled back through stall/flush/freeze.
  logic             dec_valid;
  logic [REG_W-1:0] dec_rs_a;
  logic [REG_W-1:0] dec_rs_b;
  logic             dec_use_a;
  logic             dec_use_b;
  logic [REG_W-1:0] dec_rd;
  logic             dec_wr;
  logic             dec_load;
  logic             br_taken;
  logic             md_busy;
  logic             stall;
  logic             flush;
  logic             freeze;
  logic [SEL_W-1:0] byp_a_sel;
  logic [SEL_W-1:0] byp_b_sel;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output dec_valid, dec_rs_a, dec_rs_b, dec_use_a, dec_use_b,
           dec_rd, dec_wr, dec_load, br_taken, md_busy,
    input  stall, flush, freeze, byp_a_sel, byp_b_sel,
           wb_valid, wb_rd, stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_valid, dec_rs_a, dec_rs_b, dec_use_a, dec_use_b,
           dec_rd, dec_wr, dec_load, br_taken, md_busy,
    output stall, flush, freeze, byp_a_sel, byp_b_sel,
           wb_valid, wb_rd, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: tracks in-flight destinations over DEPTH stages
// after decode and derives stall, flush, freeze, bypass selects and counters.
module pipe_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int CNT_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
  } entry_t;

  entry_t           ent_q [1:DEPTH];
  entry_t           ent1_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall, flush, freeze, load_hit;
  logic [SEL_W-1:0] sel_a, sel_b;

  function automatic logic match(entry_t e, logic [REG_W-1:0] src);
    return e.valid && e.wr && (e.rd == src) && (src != '0);
  endfunction

  // A load still short of LOAD_RDY cannot forward yet; a reader must wait.
  always_comb begin
    load_hit = 1'b0;
    for (int k = 1; k < LOAD_RDY; k++) begin
      if (ent_q[k].load &&
          ((bus.dec_use_a && match(ent_q[k], bus.dec_rs_a)) ||
           (bus.dec_use_b && match(ent_q[k], bus.dec_rs_b))))
        load_hit = 1'b1;
    end
    freeze = bus.md_busy;
    flush  = bus.br_taken & ~bus.md_busy;
    stall  = ~bus.md_busy & ~bus.br_taken & bus.dec_valid & load_hit;
  end

  // Scan oldest to youngest so the youngest eligible producer is kept last.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match(ent_q[k], bus.dec_rs_a) && !(ent_q[k].load && (k < LOAD_RDY)))
        sel_a = SEL_W'(k);
      if (match(ent_q[k], bus.dec_rs_b) && !(ent_q[k].load && (k < LOAD_RDY)))
        sel_b = SEL_W'(k);
    end
  end

  always_comb begin
    ent1_d.valid = bus.dec_valid & ~stall & ~flush;
    ent1_d.rd    = bus.dec_rd;
    ent1_d.wr    = bus.dec_wr;
    ent1_d.load  = bus.dec_load;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= DEPTH; k++)
        ent_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!freeze) begin
      for (int k = DEPTH; k >= 2; k--)
        ent_q[k] <= ent_q[k-1];
      ent_q[1]    <= ent1_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.freeze    = freeze;
  assign bus.byp_a_sel = sel_a;
  assign bus.byp_b_sel = sel_b;
  assign bus.wb_valid  = ent_q[DEPTH].valid & ent_q[DEPTH].wr &
                         (ent_q[DEPTH].rd != '0);
  assign bus.wb_rd     = ent_q[DEPTH].rd;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: an in-flight instruction list model
// checked every cycle, plus hand-computed expectations along the sequence.
module tb_pipe_hazard_ctrl;
  localparam int REG_W    = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_RDY = 2;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;

  pipe_hazard_ctrl_if #(.REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .REG_W(REG_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #10 clock = ~clock;

  // ---------------- check helper ----------------
  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- model: list of in-flight instructions, youngest first ----------------
  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit load;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_stall_cnt;
  int     m_flush_cnt;

  function automatic bit m_produces(int k, int src);
    return mq[k-1].valid && mq[k-1].wr && (mq[k-1].rd == src) && (src != 0);
  endfunction

  function automatic bit m_stall();
    bit hz = 0;
    if (bus.md_busy || bus.br_taken || !bus.dec_valid) return 0;
    for (int k = 1; k < LOAD_RDY; k++)
      if (mq[k-1].load &&
          ((bus.dec_use_a && m_produces(k, int'(bus.dec_rs_a))) ||
           (bus.dec_use_b && m_produces(k, int'(bus.dec_rs_b)))))
        hz = 1;
    return hz;
  endfunction

  function automatic bit m_flush();
    return bus.br_taken && !bus.md_busy;
  endfunction

  function automatic int m_sel(int src);
    for (int k = 1; k <= DEPTH; k++)
      if (m_produces(k, src) && !(mq[k-1].load && k < LOAD_RDY)) return k;
    return 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq = {};
      for (int i = 0; i < DEPTH; i++) mq.push_back('{0, 0, 0, 0});
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else if (!bus.md_busy) begin
      m_ent_t e;
      bit s, f;
      s = m_stall();
      f = m_flush();
      e.valid = bus.dec_valid && !s && !f;
      e.rd    = int'(bus.dec_rd);
      e.wr    = bus.dec_wr;
      e.load  = bus.dec_load;
      if (s && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (f && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      mq.push_front(e);
      void'(mq.pop_back());
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clock) begin
    if (reset) begin
      m_ent_t old;
      old = mq[DEPTH-1];
      check("stall",     int'(bus.stall),     int'(m_stall()));
      check("flush",     int'(bus.flush),     int'(m_flush()));
      check("freeze",    int'(bus.freeze),    int'(bus.md_busy));
      check("byp_a_sel", int'(bus.byp_a_sel), m_sel(int'(bus.dec_rs_a)));
      check("byp_b_sel", int'(bus.byp_b_sel), m_sel(int'(bus.dec_rs_b)));
      check("wb_valid",  int'(bus.wb_valid),  int'(old.valid && old.wr && old.rd != 0));
      if (old.valid && old.wr && old.rd != 0)
        check("wb_rd", int'(bus.wb_rd), old.rd);
      check("stall_cnt", int'(bus.stall_cnt), m_stall_cnt);
      check("flush_cnt", int'(bus.flush_cnt), m_flush_cnt);
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit v, input int ra, input bit ua, input int rb, input bit ub,
                       input int rd, input bit wr, input bit ld, input bit br, input bit md);
    @(posedge clock);
    #1;
    bus.dec_valid = v;
    bus.dec_rs_a  = REG_W'(ra);
    bus.dec_use_a = ua;
    bus.dec_rs_b  = REG_W'(rb);
    bus.dec_use_b = ub;
    bus.dec_rd    = REG_W'(rd);
    bus.dec_wr    = wr;
    bus.dec_load  = ld;
    bus.br_taken  = br;
    bus.md_busy   = md;
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    bus.dec_valid = 0; bus.dec_rs_a = '0; bus.dec_use_a = 0; bus.dec_rs_b = '0;
    bus.dec_use_b = 0; bus.dec_rd = '0; bus.dec_wr = 0; bus.dec_load = 0;
    bus.br_taken = 0; bus.md_busy = 0;
    #25;
    check("rst stall",     int'(bus.stall),     0);
    check("rst flush",     int'(bus.flush),     0);
    check("rst freeze",    int'(bus.freeze),    0);
    check("rst sel_a",     int'(bus.byp_a_sel), 0);
    check("rst wb_valid",  int'(bus.wb_valid),  0);
    check("rst stall_cnt", int'(bus.stall_cnt), 0);
    check("rst flush_cnt", int'(bus.flush_cnt), 0);
    @(posedge clock); #1 reset = 1'b1;

    // add r3; sub r4 <- r3; reader <- r3
    issue(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    issue(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    check("fwd1 sel_a", int'(bus.byp_a_sel), 1);
    issue(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    check("fwd2 sel_a", int'(bus.byp_a_sel), 2);
    nop();
    check("wb add valid", int'(bus.wb_valid), 1);
    check("wb add rd",    int'(bus.wb_rd),    3);

    // lw r5; add r6 <- r5 (B): one stall, then forward from stage 2
    issue(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    issue(1, 0, 0, 5, 1, 6, 1, 0, 0, 0);
    check("lu stall",     int'(bus.stall),     1);
    check("lu sel_b",     int'(bus.byp_b_sel), 0);
    issue(1, 0, 0, 5, 1, 6, 1, 0, 0, 0);
    check("lu stall rel", int'(bus.stall),     0);
    check("lu sel_b2",    int'(bus.byp_b_sel), 2);
    check("lu stall_cnt", int'(bus.stall_cnt), 1);
    issue(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    check("lu fwd r6",    int'(bus.byp_a_sel), 1);
    check("lu wb rd",     int'(bus.wb_rd),     5);
    nop();
    check("bubble wb",    int'(bus.wb_valid),  0);

    // r0 never hazards or forwards
    issue(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    issue(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("r0 stall", int'(bus.stall),     0);
    check("r0 sel_a", int'(bus.byp_a_sel), 0);
    nop();
    nop();
    check("r0 wb",    int'(bus.wb_valid),  0);

    // load-use with branch taken: flush wins
    issue(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    issue(1, 9, 1, 0, 0, 10, 1, 0, 1, 0);
    check("br flush", int'(bus.flush), 1);
    check("br stall", int'(bus.stall), 0);
    issue(1, 10, 1, 9, 1, 0, 0, 0, 0, 0);
    check("br killed sel_a", int'(bus.byp_a_sel), 0);
    check("br sel_b",        int'(bus.byp_b_sel), 2);
    check("br flush_cnt",    int'(bus.flush_cnt), 1);
    check("br stall_cnt",    int'(bus.stall_cnt), 1);

    // freeze over branch + load hazard, then release
    issue(1, 0, 0, 0, 0, 11, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      issue(1, 11, 1, 0, 0, 12, 1, 0, 1, 1);
      check("frz freeze", int'(bus.freeze),    1);
      check("frz stall",  int'(bus.stall),     0);
      check("frz flush",  int'(bus.flush),     0);
      check("frz fcnt",   int'(bus.flush_cnt), 1);
      check("frz scnt",   int'(bus.stall_cnt), 1);
    end
    issue(1, 11, 1, 0, 0, 12, 1, 0, 1, 0);
    check("frz rel flush", int'(bus.flush), 1);
    check("frz rel stall", int'(bus.stall), 0);
    nop();
    check("frz rel fcnt", int'(bus.flush_cnt), 2);

    // two writers to r7: youngest wins
    issue(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    issue(1, 7, 1, 7, 1, 0, 0, 0, 0, 0);
    check("young sel_a", int'(bus.byp_a_sel), 1);
    check("young sel_b", int'(bus.byp_b_sel), 1);

    // reset mid-operation with a load hazard pending
    issue(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);
    issue(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
    check("mid stall", int'(bus.stall), 1);
    #1 reset = 1'b0;
    #1;
    check("mid rst stall", int'(bus.stall),     0);
    check("mid rst scnt",  int'(bus.stall_cnt), 0);
    check("mid rst fcnt",  int'(bus.flush_cnt), 0);
    #1 reset = 1'b1;
    issue(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
    check("post rst stall", int'(bus.stall),     0);
    check("post rst sel",   int'(bus.byp_a_sel), 0);

    // drive 16 load-use stalls into a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      issue(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
      issue(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
      check("sat stall", int'(bus.stall), 1);
    end
    check("sat before", int'(bus.stall_cnt), 15);
    nop();
    check("sat hold",   int'(bus.stall_cnt), 15);
    nop();
    nop();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
